sdram_rd_stream: RTL

Parametrised SDRAM read engine, the next generation of the single-bank VGA frame reader. It sits behind the SDRAM command arbiter. It reads a frame of ROWS rows × COLS columns row by row from a software-selected bank, using back-to-back bursts. It yields to refresh mid-row and resumes at the next burst. Read data goes out as a valid/data stream to an external buffer; no FIFO is inside this block.

---
 rtl/sdram_pkg.sv | 48 ++++
 rtl/sdram_rd_valid_pipe.sv | 33 +++
 rtl/sdram_rd_stream.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/sdram_pkg.sv
// -----------------------------------------------------------------------------
// sdram_pkg
// Shared SDRAM definitions for the read engine:
//   - 4-bit command encodings {cs_n, ras_n, cas_n, we_n}
//   - read-engine state enum
//   - pack_cmd(): packs {cmd, ba, addr} into a command word
// pack_cmd() returns a word sized for the widest supported bus (BA up to
// CMD_BA_MAX bits, address up to CMD_ADDR_MAX bits). The caller truncates it
// to its own 4+BA_W+ADDR_W width.
// -----------------------------------------------------------------------------
package sdram_pkg;

    localparam logic [3:0] CMD_NOP  = 4'b0111;
    localparam logic [3:0] CMD_ACT  = 4'b0011;
    localparam logic [3:0] CMD_RD   = 4'b0101;
    localparam logic [3:0] CMD_WR   = 4'b0100;
    localparam logic [3:0] CMD_PALL = 4'b0010;
    localparam logic [3:0] CMD_REF  = 4'b0001;

    localparam int CMD_BA_MAX   = 8;
    localparam int CMD_ADDR_MAX = 16;
    localparam int CMD_MAX_W    = 4 + CMD_BA_MAX + CMD_ADDR_MAX;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ,
        ST_ACTIVE,
        ST_READ,
        ST_PRECHARGE
    } state_t;

    // The result sits in the low 4+ba_w+addr_w bits. ba and addr must
    // already be zero above their real widths.
    function automatic logic [CMD_MAX_W-1:0] pack_cmd(
        input logic [3:0]              cmd,
        input logic [CMD_BA_MAX-1:0]   ba,
        input logic [CMD_ADDR_MAX-1:0] addr,
        input int unsigned             ba_w,
        input int unsigned             addr_w
    );
        logic [CMD_MAX_W-1:0] v;
        v = CMD_MAX_W'(cmd);
        v = (v << ba_w) | CMD_MAX_W'(ba);
        v = (v << addr_w) | CMD_MAX_W'(addr);
        return v;
    endfunction

endpackage

// File: rtl/sdram_rd_valid_pipe.sv
// -----------------------------------------------------------------------------
// sdram_rd_valid_pipe
// Delays the "engine is in READ" flag by DEPTH cycles. The delayed flag
// marks the cycle in which the matching SDRAM word is held in rd_data.
// Ports:
//   clk, rst   clock, synchronous active-high reset
//   i_in_read  1 while the engine is in READ
//   o_valid    i_in_read delayed by DEPTH cycles
// -----------------------------------------------------------------------------
module sdram_rd_valid_pipe #(
    parameter int DEPTH = 5
) (
    input  logic clk,
    input  logic rst,
    input  logic i_in_read,
    output logic o_valid
);

    logic [DEPTH-1:0] r_pipe;

    // NOTE: this is a small shift register, not a RAM. It is cleared on
    // reset so that reads in flight when reset hits never show up as valid.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pipe <= '0;
        end else begin
            r_pipe <= {r_pipe[DEPTH-2:0], i_in_read};
        end
    end

    assign o_valid = r_pipe[DEPTH-1];

endmodule

// File: rtl/sdram_rd_stream.sv
// -----------------------------------------------------------------------------
// sdram_rd_stream
// SDRAM frame read engine. It reads ROWS x COLS words row by row from one
// bank using back-to-back bursts. It gives way to refresh between bursts and
// streams the read data out as valid/data.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   fill_req        downstream can take one full row
//   frame_bank      bank for the next frame (sampled at frame start)
//   r_req / r_en    arbiter request / grant
//   ref_req         refresh pending
//   r_cmd           registered {cs_n,ras_n,cas_n,we_n,ba,addr}
//   r_dq            SDRAM data pins
//   rd_valid        rd_data holds a read word
//   rd_data         read word
//   ref_break_end   last PRECHARGE cycle after a refresh break
//   row_end         last PRECHARGE cycle after a completed row
//   frame_end       row_end of the last row of the frame
//   cur_row         row being read, or the next row to read
// -----------------------------------------------------------------------------
module sdram_rd_stream
    import sdram_pkg::*;
#(
    parameter int DQ_W   = 16,
    parameter int ADDR_W = 12,
    parameter int BA_W   = 2,
    parameter int BL     = 4,
    parameter int COLS   = 512,
    parameter int ROWS   = 300,
    parameter int CL     = 3,
    parameter int T_RCD  = 4,
    parameter int T_PRE  = 9
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       fill_req,
    input  logic [BA_W-1:0]            frame_bank,
    output logic                       r_req,
    input  logic                       r_en,
    input  logic                       ref_req,
    output logic [4+BA_W+ADDR_W-1:0]   r_cmd,
    input  logic [DQ_W-1:0]            r_dq,
    output logic                       rd_valid,
    output logic [DQ_W-1:0]            rd_data,
    output logic                       ref_break_end,
    output logic                       row_end,
    output logic                       frame_end,
    output logic [ADDR_W-1:0]          cur_row
);

    localparam int N_BURSTS = COLS / BL;
    localparam int PH_MAX   = (T_PRE > T_RCD) ? T_PRE : T_RCD;
    localparam int PH_W     = $clog2(PH_MAX);
    localparam int BC_W     = (BL > 1) ? $clog2(BL) : 1;
    localparam int CI_W     = (N_BURSTS > 1) ? $clog2(N_BURSTS) : 1;
    localparam int CMD_W    = 4 + BA_W + ADDR_W;
    localparam logic [ADDR_W-1:0] ADDR_A10 = ADDR_W'(1) << 10;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [PH_W-1:0]   r_phase;      // cycle index within ACTIVE / PRECHARGE
    logic [BC_W-1:0]   r_burst_cnt;
    logic [CI_W-1:0]   r_col_idx;    // next burst to read in the current row
    logic [ADDR_W-1:0] r_cur_row;
    logic [BA_W-1:0]   r_bank;
    logic              r_row_done;   // the last READ exit finished the row
    logic [DQ_W-1:0]   r_rd_data;

    logic              w_burst_last;
    logic              w_row_last_burst;
    logic              w_act_last;
    logic              w_pre_last;
    logic [3:0]        w_cmd_code;
    logic [BA_W-1:0]   w_cmd_ba;
    logic [ADDR_W-1:0] w_cmd_addr;

    assign w_burst_last     = (r_burst_cnt == BC_W'(BL - 1));
    assign w_row_last_burst = (r_col_idx == CI_W'(N_BURSTS - 1));
    assign w_act_last       = (r_phase == PH_W'(T_RCD - 1));
    assign w_pre_last       = (r_phase == PH_W'(T_PRE - 1));

    // ---------------- state register ----------------
    // NOTE: every clocked block uses non-blocking assignments, so all
    // registers update together from values sampled at the same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ---------------- next state and state-decoded outputs ----------------
    // NOTE: every output of this block gets a default first. Without that,
    // a path that leaves one unassigned would infer a latch.
    always_comb begin
        w_state_nxt   = r_state;
        r_req         = 1'b0;
        row_end       = 1'b0;
        frame_end     = 1'b0;
        ref_break_end = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (fill_req) w_state_nxt = ST_REQ;
            end
            ST_REQ: begin
                r_req = 1'b1;
                if (r_en) w_state_nxt = ST_ACTIVE;
            end
            ST_ACTIVE: begin
                if (w_act_last) w_state_nxt = ST_READ;
            end
            ST_READ: begin
                // A refresh only matters on the last cycle of a burst. On the
                // row's final burst it is ignored and the row completes.
                if (w_burst_last && (w_row_last_burst || ref_req))
                    w_state_nxt = ST_PRECHARGE;
            end
            ST_PRECHARGE: begin
                if (w_pre_last) begin
                    if (r_row_done) begin
                        w_state_nxt = ST_IDLE;
                        row_end     = 1'b1;
                        frame_end   = (r_cur_row == ADDR_W'(ROWS - 1));
                    end else begin
                        w_state_nxt   = ST_REQ;
                        ref_break_end = 1'b1;
                    end
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // ---------------- counters, bank, read data ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_phase     <= '0;
            r_burst_cnt <= '0;
            r_col_idx   <= '0;
            r_cur_row   <= '0;
            r_bank      <= '0;
            r_row_done  <= 1'b0;
            r_rd_data   <= '0;
        end else begin
            r_rd_data <= r_dq;

            if (w_state_nxt != r_state)
                r_phase <= '0;
            else if (r_state == ST_ACTIVE || r_state == ST_PRECHARGE)
                r_phase <= r_phase + PH_W'(1);

            if (r_state == ST_READ && !w_burst_last)
                r_burst_cnt <= r_burst_cnt + BC_W'(1);
            else
                r_burst_cnt <= '0;

            // col_idx is kept across a refresh break, so the row resumes at
            // the first burst that has not been read yet.
            if (r_state == ST_READ && w_burst_last) begin
                r_row_done <= w_row_last_burst;
                r_col_idx  <= w_row_last_burst ? '0 : r_col_idx + CI_W'(1);
            end

            if (r_state == ST_PRECHARGE && w_pre_last && r_row_done)
                r_cur_row <= (r_cur_row == ADDR_W'(ROWS - 1)) ? '0
                                                               : r_cur_row + ADDR_W'(1);

            // The bank is chosen only at frame start and holds for the frame.
            if (r_state == ST_IDLE && fill_req && r_cur_row == '0 && r_col_idx == '0)
                r_bank <= frame_bank;
        end
    end

    // ---------------- command register ----------------
    always_comb begin
        w_cmd_code = CMD_NOP;
        w_cmd_ba   = '0;
        w_cmd_addr = '0;
        if (r_state == ST_ACTIVE && r_phase == '0) begin
            w_cmd_code = CMD_ACT;
            w_cmd_ba   = r_bank;
            w_cmd_addr = r_cur_row;
        end else if (r_state == ST_READ && r_burst_cnt == '0) begin
            w_cmd_code = CMD_RD;
            w_cmd_ba   = r_bank;
            w_cmd_addr = ADDR_W'(r_col_idx) << $clog2(BL);
        end else if (r_state == ST_PRECHARGE && r_phase == '0) begin
            w_cmd_code = CMD_PALL;
            w_cmd_addr = ADDR_A10;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cmd <= CMD_W'(pack_cmd(CMD_NOP, '0, '0, BA_W, ADDR_W));
        end else begin
            r_cmd <= CMD_W'(pack_cmd(w_cmd_code, CMD_BA_MAX'(w_cmd_ba),
                                     CMD_ADDR_MAX'(w_cmd_addr), BA_W, ADDR_W));
        end
    end

    // ---------------- valid alignment ----------------
    // A READ cycle at t puts RD on r_cmd at t+1, data on r_dq at t+1+CL and
    // the word in rd_data at t+2+CL.
    sdram_rd_valid_pipe #(
        .DEPTH (CL + 2)
    ) u_valid_pipe (
        .clk       (clk),
        .rst       (rst),
        .i_in_read (r_state == ST_READ),
        .o_valid   (rd_valid)
    );

    assign rd_data = r_rd_data;
    assign cur_row = r_cur_row;

endmodule
